csr_file: RTL and testbench

- Machine-mode control and status register file for the RV32I `cpu`.
- Sits directly downstream of the instruction decoder. It consumes decoded CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI requests and returns the old CSR value for writeback to rd.
- Also holds the trap state (mepc, mcause, mtval, mstatus.MIE/MPIE) and the cycle/instret counters.
- It is the block exercised by the CSR instruction test bench.

---
 rtl/csr_file_if.sv | 35 +++
 rtl/csr_file.sv | 233 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// -----------------------------------------------------------------------------
// csr_file_if
// Request/response bus between the instruction decoder and the CSR file.
//
// Signals:
//   valid    decoder -> csr  request present, held until ack
//   addr     decoder -> csr  12-bit CSR address (instr[31:20])
//   funct3   decoder -> csr  instr[14:12]; [1:0] = 01 write, 10 set, 11 clear
//   wdata    decoder -> csr  rs1 value or zero-extended zimm
//   src_zero decoder -> csr  rs1/zimm field is zero (set/clear do not write)
//   ack      csr -> decoder  one-cycle completion pulse
//   rdata    csr -> decoder  CSR value before the write (0 when illegal)
//   illegal  csr -> decoder  access rejected, no state changed
// Modports: master = decoder side, slave = CSR file side.
// -----------------------------------------------------------------------------
interface csr_file_if;
  logic        valid;
  logic [11:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        src_zero;
  logic        ack;
  logic [31:0] rdata;
  logic        illegal;

  modport master (
    output valid, addr, funct3, wdata, src_zero,
    input  ack, rdata, illegal
  );

  modport slave (
    input  valid, addr, funct3, wdata, src_zero,
    output ack, rdata, illegal
  );
endinterface

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR file for the RV32I core. Executes decoded Zicsr requests
// (read-modify-write with one-cycle ack), holds trap state and the 64-bit
// mcycle/minstret counters.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   bus           csr_file_if.slave request/response bus
//   retire_i      one instruction retired this cycle (minstret increment)
//   trap_i        trap entry pulse (captures mepc/mcause/mtval, stacks MIE)
//   trap_pc_i     PC of the trapping instruction
//   trap_cause_i  value loaded into mcause
//   trap_tval_i   value loaded into mtval
//   mret_i        MRET executed this cycle (unstacks MIE)
//   mtvec_o       current mtvec
//   mepc_o        current mepc
//   mie_o         current mstatus.MIE
// -----------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h1000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  csr_file_if.slave        bus,
  input  logic             retire_i,
  input  logic             trap_i,
  input  logic [31:0]      trap_pc_i,
  input  logic [31:0]      trap_cause_i,
  input  logic [31:0]      trap_tval_i,
  input  logic             mret_i,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      mepc_o,
  output logic             mie_o
);

  // CSR addresses
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Architectural state
  logic        mie_q;
  logic        mpie_q;
  logic [2:0]  mie_en_q;     // mie bits {11, 7, 3}
  logic [31:2] mtvec_q;
  logic [31:2] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mscratch_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // Response registers
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        illegal_q;

  // Request decode
  op_e         op;
  logic [31:0] old_val;
  logic        known;
  logic        wants_write;
  logic        illegal;
  logic        accept;
  logic        commit;
  logic [31:0] new_val;

  assign op = op_e'(bus.funct3[1:0]);

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    old_val = 32'd0;
    known   = 1'b1;
    case (bus.addr)
      A_MSTATUS:              old_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MISA:                 old_val = MISA_VALUE;
      A_MIE:                  old_val = {20'd0, mie_en_q[2], 3'd0, mie_en_q[1], 3'd0,
                                         mie_en_q[0], 3'd0};
      A_MIP:                  old_val = 32'd0;
      A_MTVEC:                old_val = {mtvec_q, 2'b00};
      A_MSCRATCH:             old_val = mscratch_q;
      A_MEPC:                 old_val = {mepc_q, 2'b00};
      A_MCAUSE:               old_val = mcause_q;
      A_MTVAL:                old_val = mtval_q;
      A_MCYCLE,   A_CYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH,  A_CYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH,A_INSTRETH: old_val = minstret_q[63:32];
      A_MVENDORID, A_MARCHID, A_MIMPID: old_val = 32'd0;
      A_MHARTID:              old_val = HART_ID;
      default:                known   = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      OP_WRITE: new_val = bus.wdata;
      OP_SET:   new_val = old_val | bus.wdata;
      OP_CLEAR: new_val = old_val & ~bus.wdata;
      default:  new_val = old_val;
    endcase
  end

  // Set/clear with a zero source is a pure read, so it is legal even on the
  // read-only 0xCxx/0xFxx space. funct3[1:0]=00 is not a CSR op at all.
  assign wants_write = (op == OP_WRITE) ||
                       (((op == OP_SET) || (op == OP_CLEAR)) && !bus.src_zero);
  assign illegal     = !known || (op == OP_NONE) ||
                       ((bus.addr[11:10] == 2'b11) && wants_write);

  // Trap entry and MRET own the trap state that cycle, so the request waits.
  assign accept = bus.valid && !ack_q && !trap_i && !mret_i;
  assign commit = accept && wants_write && !illegal;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign wr_mstatus   = commit && (bus.addr == A_MSTATUS);
  assign wr_mie       = commit && (bus.addr == A_MIE);
  assign wr_mtvec     = commit && (bus.addr == A_MTVEC);
  assign wr_mscratch  = commit && (bus.addr == A_MSCRATCH);
  assign wr_mepc      = commit && (bus.addr == A_MEPC);
  assign wr_mcause    = commit && (bus.addr == A_MCAUSE);
  assign wr_mtval     = commit && (bus.addr == A_MTVAL);
  assign wr_mcycle    = commit && (bus.addr == A_MCYCLE);
  assign wr_mcycleh   = commit && (bus.addr == A_MCYCLEH);
  assign wr_minstret  = commit && (bus.addr == A_MINSTRET);
  assign wr_minstreth = commit && (bus.addr == A_MINSTRETH);

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      illegal_q  <= 1'b0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_en_q   <= 3'd0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mepc_q     <= 30'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        rdata_q   <= illegal ? 32'd0 : old_val;
        illegal_q <= illegal;
      end

      // commit can only be high when neither trap_i nor mret_i is.
      if (trap_i) begin
        mepc_q   <= trap_pc_i[31:2];
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_i) begin
        mie_q    <= mpie_q;
        mpie_q   <= 1'b1;
      end else begin
        if (wr_mstatus) begin
          mie_q  <= new_val[3];
          mpie_q <= new_val[7];
        end
        if (wr_mie)      mie_en_q   <= {new_val[11], new_val[7], new_val[3]};
        if (wr_mtvec)    mtvec_q    <= new_val[31:2];
        if (wr_mscratch) mscratch_q <= new_val;
        if (wr_mepc)     mepc_q     <= new_val[31:2];
        if (wr_mcause)   mcause_q   <= new_val;
        if (wr_mtval)    mtval_q    <= new_val;
      end

      // A software write to either half replaces that cycle's increment.
      if (wr_mcycle)       mcycle_q[31:0]  <= new_val;
      else if (wr_mcycleh) mcycle_q[63:32] <= new_val;
      else                 mcycle_q        <= mcycle_q + 64'd1;

      if (wr_minstret)       minstret_q[31:0]  <= new_val;
      else if (wr_minstreth) minstret_q[63:32] <= new_val;
      else if (retire_i)     minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.illegal = illegal_q;

  assign mtvec_o = {mtvec_q, 2'b00};
  assign mepc_o  = {mepc_q, 2'b00};
  assign mie_o   = mie_q;

  // funct3[2] (register vs immediate form) is resolved by the decoder into
  // wdata; the low PC bits are dropped because mepc is word aligned.
  logic unused_bits;
  assign unused_bits = ^{bus.funct3[2], trap_pc_i[1:0]};

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
// Self-checking bench for csr_file. Requests are issued through the interface;
// each request pushes its expected rdata/illegal onto a scoreboard queue that
// a negedge monitor pops whenever ack is seen.
// -----------------------------------------------------------------------------
module tb_csr_file;
  localparam logic [31:0] HART  = 32'd5;
  localparam logic [31:0] TVEC0 = 32'h1000_0000;

  localparam logic [2:0] F_RW  = 3'b001;
  localparam logic [2:0] F_RS  = 3'b010;
  localparam logic [2:0] F_RC  = 3'b011;
  localparam logic [2:0] F_RSI = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire, trap, mret;
  logic [31:0] trap_pc, trap_cause, trap_tval;
  logic [31:0] mtvec, mepc;
  logic        mie;

  csr_file_if bus ();

  csr_file #(.HART_ID(HART), .MTVEC_RESET(TVEC0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .retire_i     (retire),
    .trap_i       (trap),
    .trap_pc_i    (trap_pc),
    .trap_cause_i (trap_cause),
    .trap_tval_i  (trap_tval),
    .mret_i       (mret),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc),
    .mie_o        (mie)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        illegal;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.ack === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_rdata) check({e.tag, "_rdata"}, bus.rdata, e.rdata);
        check({e.tag, "_illegal"}, 32'(bus.illegal), 32'(e.illegal));
      end
    end
  end

  // One complete request: drive, wait (bounded) for ack, then confirm the ack
  // drops after a single cycle.
  task automatic req(input string tag, input logic [11:0] a, input logic [2:0] f,
                     input logic [31:0] wd, input logic sz,
                     input logic [31:0] er, input logic ei, input logic chk = 1'b1);
    bit got;
    exp_t e;
    e = '{tag, er, ei, chk};
    sb.push_back(e);
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.addr     = a;
    bus.funct3   = f;
    bus.wdata    = wd;
    bus.src_zero = sz;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    bus.valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, 32'(bus.ack), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; retire = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_pc = '0; trap_cause = '0; trap_tval = '0;
    bus.valid = 1'b0; bus.addr = '0; bus.funct3 = '0; bus.wdata = '0; bus.src_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_mtvec", mtvec, TVEC0);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mie", 32'(mie), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // mepc alignment
    req("mepc_rw", 12'h341, F_RW, 32'h2000_0007, 1'b0, 32'd0, 1'b0);
    check("mepc_o", mepc, 32'h2000_0004);
    req("mepc_rs0", 12'h341, F_RS, 32'd0, 1'b1, 32'h2000_0004, 1'b0);

    // mscratch read-modify-write
    req("mscr_rw", 12'h340, F_RW, 32'hF0F0_0000, 1'b0, 32'd0, 1'b0);
    req("mscr_rs", 12'h340, F_RS, 32'h0000_00FF, 1'b0, 32'hF0F0_0000, 1'b0);
    req("mscr_rc", 12'h340, F_RC, 32'hF000_000F, 1'b0, 32'hF0F0_00FF, 1'b0);
    req("mscr_rd", 12'h340, F_RSI, 32'd0, 1'b1, 32'h00F0_00F0, 1'b0);

    // id registers, illegal accesses, WARL fields
    req("hartid_rd", 12'hF14, F_RS, 32'd0, 1'b1, HART, 1'b0);
    req("hartid_wr", 12'hF14, F_RW, 32'd1, 1'b0, 32'd0, 1'b1);
    req("unk_wr", 12'h7C0, F_RW, 32'h1234_5678, 1'b0, 32'd0, 1'b1);
    req("misa_wr", 12'h301, F_RW, 32'd0, 1'b0, 32'h4000_0100, 1'b0);
    req("misa_rd", 12'h301, F_RS, 32'd0, 1'b1, 32'h4000_0100, 1'b0);
    req("mip_wr", 12'h344, F_RW, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    req("mtvec_wr", 12'h305, F_RW, 32'h2000_0003, 1'b0, TVEC0, 1'b0);
    check("mtvec_o", mtvec, 32'h2000_0000);
    req("mie_wr", 12'h304, F_RW, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    req("mie_rd", 12'h304, F_RS, 32'd0, 1'b1, 32'h0000_0888, 1'b0);
    req("mstatus_rd", 12'h300, F_RS, 32'd0, 1'b1, 32'h0000_1800, 1'b0);
    req("cycleh_rd", 12'hC80, F_RS, 32'd0, 1'b1, 32'd0, 1'b0);
    req("cycleh_rs", 12'hC80, F_RS, 32'd1, 1'b0, 32'd0, 1'b1);

    // mcycle low-word wrap carries into mcycleh
    req("mcycle_wr", 12'hB00, F_RW, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    req("mcycleh_rd", 12'hB80, F_RS, 32'd0, 1'b1, 32'd1, 1'b0);

    // minstret counts retire pulses
    req("minstret_wr", 12'hB02, F_RW, 32'h0000_0100, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    retire = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    retire = 1'b0;
    req("instret_rd", 12'hC02, F_RSI, 32'd0, 1'b1, 32'h0000_0105, 1'b0);
    req("instreth_rd", 12'hC82, F_RSI, 32'd0, 1'b1, 32'd0, 1'b0);

    // trap entry and MRET
    req("mie_set", 12'h300, F_RS, 32'h0000_0008, 1'b0, 32'h0000_1800, 1'b0);
    check("mie_on", 32'(mie), 32'd1);
    @(negedge clk);
    trap = 1'b1; trap_pc = 32'h1000_0102; trap_cause = 32'd11; trap_tval = 32'h0000_0055;
    @(posedge clk); #1;
    trap = 1'b0;
    check("trap_mepc", mepc, 32'h1000_0100);
    check("trap_mie", 32'(mie), 32'd0);
    req("trap_mstatus", 12'h300, F_RS, 32'd0, 1'b1, 32'h0000_1880, 1'b0);
    req("trap_mcause", 12'h342, F_RS, 32'd0, 1'b1, 32'd11, 1'b0);
    req("trap_mtval", 12'h343, F_RS, 32'd0, 1'b1, 32'h0000_0055, 1'b0);
    @(negedge clk);
    mret = 1'b1;
    @(posedge clk); #1;
    mret = 1'b0;
    check("mret_mie", 32'(mie), 32'd1);
    req("mret_mstatus", 12'h300, F_RS, 32'd0, 1'b1, 32'h0000_1888, 1'b0);

    // request arriving together with a trap is deferred one cycle
    sb.push_back('{"defer", 32'h00F0_00F0, 1'b0, 1'b1});
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = 12'h340; bus.funct3 = F_RS; bus.wdata = 32'd0; bus.src_zero = 1'b1;
    trap = 1'b1; trap_pc = 32'h3000_0008; trap_cause = 32'd2; trap_tval = 32'd0;
    @(posedge clk); #1;
    trap = 1'b0;
    check("defer_ack0", 32'(bus.ack), 32'd0);
    @(posedge clk); #1;
    check("defer_ack1", 32'(bus.ack), 32'd1);
    bus.valid = 1'b0;
    @(posedge clk); #1;
    check("defer_ack2", 32'(bus.ack), 32'd0);
    check("defer_mepc", mepc, 32'h3000_0008);
    check("defer_mie", 32'(mie), 32'd0);

    // reset on the accepting edge drops the request and its write
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = 12'h305; bus.funct3 = F_RW; bus.wdata = 32'h4000_0000; bus.src_zero = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstreq_ack", 32'(bus.ack), 32'd0);
    check("rstreq_mtvec", mtvec, TVEC0);
    check("rstreq_mepc", mepc, 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstreq_noack", 32'(bus.ack), 32'd0);
    req("post_rst_mscr", 12'h340, F_RS, 32'd0, 1'b1, 32'd0, 1'b0);

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
